// File: rtl/uart_bus.sv
// Memory-mapped UART: 4-word register window, 8-entry TX FIFO feeding a
// serialiser on tx, and a single-byte receive holding register fed from rx.
// Read data is combinational on the bus address and zero when not selected.
module uart_bus #(
  parameter logic [29:0] BASE        = 30'h3FFF_FFF0,
  parameter int unsigned DIV_DEFAULT = 217,
  parameter int unsigned TX_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Bus decode
  logic       sel;
  logic [1:0] reg_sel;
  logic       data_wr, stat_wr, div_lo_wr, div_hi_wr;

  assign sel       = (bus_addr[29:2] == BASE[29:2]);
  assign reg_sel   = bus_addr[1:0];
  assign data_wr   = sel & bus_mask_w[0] & (reg_sel == 2'd0);
  assign stat_wr   = sel & bus_mask_w[0] & (reg_sel == 2'd1);
  assign div_lo_wr = sel & bus_mask_w[0] & (reg_sel == 2'd2);
  assign div_hi_wr = sel & bus_mask_w[1] & (reg_sel == 2'd2);

  // Bits of the bus that no register field covers
  logic unused_bus;
  assign unused_bus = ^{bus_data_w[31:16], bus_mask_w[3:2]};

  // Divisor and derived bit periods (zero behaves as one)
  logic [15:0] div_q, div_d;
  logic [15:0] period, half_period;

  assign period      = (div_q == 16'd0) ? 16'd1 : div_q;
  assign half_period = ((period >> 1) == 16'd0) ? 16'd1 : (period >> 1);

  // FIFO control
  logic [7:0]       fifo_q [TX_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_full, push, pop, ovf_set;
  logic [7:0]       fifo_head;

  assign tx_full   = (count_q == DEPTH_C);
  assign push      = data_wr & ~tx_full;
  assign ovf_set   = data_wr & tx_full;
  assign fifo_head = fifo_q[rptr_q];

  // TX state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_busy;

  // RX state
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done, ferr_set;

  // Sticky flags and receive holding register
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       frame_err_q, frame_err_d;
  logic       clr_valid, clr_ovf, clr_ovr, clr_ferr;

  assign clr_valid = stat_wr & bus_data_w[2];
  assign clr_ovf   = stat_wr & bus_data_w[3];
  assign clr_ovr   = stat_wr & bus_data_w[4];
  assign clr_ferr  = stat_wr & bus_data_w[5];

  assign tx_busy = (tx_state_q != TX_IDLE) | (count_q != '0);
  assign tx      = tx_q;
  assign irq     = rx_valid_q;

  // Divisor next-state: each byte lane writes its half independently
  always_comb begin
    div_d = div_q;
    if (div_lo_wr) div_d[7:0]  = bus_data_w[7:0];
    if (div_hi_wr) div_d[15:8] = bus_data_w[15:8];
  end

  // FIFO pointer and occupancy next-state; push is refused whenever full
  always_comb begin
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clock) begin
    if (push) fifo_q[wptr_q] <= bus_data_w[7:0];
  end

  // TX next-state: every bit reloads the counter so a new divisor lands on a bit boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop        = 1'b1;
          tx_shift_d = fifo_head;
          tx_cnt_d   = period;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd1) begin
          tx_cnt_d   = period;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd1) begin
          tx_cnt_d = period;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd1) begin
          if (count_q != '0) begin
            pop        = 1'b1;
            tx_shift_d = fifo_head;
            tx_cnt_d   = period;
            tx_d       = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // RX next-state: wait half a period to the start-bit centre, then sample at full periods
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q & ~rx_s2_q) begin
          rx_cnt_d   = half_period;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd1) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = period;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd1) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = period;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd1) begin
          rx_done    = rx_s2_q;
          ferr_set   = ~rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Flag next-state: a set event in the same cycle as its clear wins
  always_comb begin
    rx_data_d   = rx_done ? rx_shift_q : rx_data_q;
    rx_valid_d  = (rx_valid_q & ~clr_valid) | rx_done;
    rx_ovr_d    = (rx_ovr_q & ~clr_ovr) | (rx_done & rx_valid_q & ~clr_valid);
    tx_ovf_d    = (tx_ovf_q & ~clr_ovf) | ovf_set;
    frame_err_d = (frame_err_q & ~clr_ferr) | ferr_set;
  end

  // Control, flag and divisor registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q       <= 16'(DIV_DEFAULT);
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  // TX state register; line idles high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // RX synchroniser, edge history and state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Read mux: side-effect free, zero outside the window
  always_comb begin
    bus_data_r = 32'd0;
    if (sel) begin
      case (reg_sel)
        2'd0:    bus_data_r = {23'd0, rx_valid_q, rx_data_q};
        2'd1:    bus_data_r = {26'd0, frame_err_q, rx_ovr_q, tx_ovf_q,
                               rx_valid_q, tx_full, tx_busy};
        2'd2:    bus_data_r = {16'd0, div_q};
        default: bus_data_r = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus.sv
// Bench for uart_bus: register vector table, TX scoreboard fed by a line
// monitor, and hand-written sequences for timing, RX framing and reset.
module tb_uart_bus;

  localparam logic [29:0] BASE = 30'h3FFF_FFF0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] bus_addr = '0;
  logic [31:0] bus_data_w = '0;
  logic [3:0]  bus_mask_w = '0;
  logic [31:0] bus_data_r;
  logic        tx;
  logic        rx = 1'b1;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  uart_bus #(.BASE(BASE), .DIV_DEFAULT(217), .TX_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_data_w(bus_data_w),
    .bus_mask_w(bus_mask_w), .bus_data_r(bus_data_r), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    bus_addr = a; bus_data_w = d; bus_mask_w = m;
    @(negedge clock);
    bus_mask_w = 4'h0;
  endtask

  task automatic rd_chk(input string name, input logic [29:0] a, input logic [31:0] exp);
    @(negedge clock);
    bus_addr = a; bus_mask_w = 4'h0;
    #1 chk(name, bus_data_r, exp);
  endtask

  // Drive one frame with a 4-cycle bit period, then idle high
  task automatic send_rx(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(negedge clock); rx = f[j];
      repeat (3) @(negedge clock);
    end
    @(negedge clock); rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock); n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // TX line monitor: decodes frames at 4 cycles per bit, drops frames cut by reset
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       stp;
    int         st, rc;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (reset && prev && tx == 1'b0) begin
        st = cyc; rc = rst_cnt;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clock);
          b[i] = tx;
        end
        repeat (4) @(negedge clock);
        stp = tx;
        if (rc == rst_cnt && reset) begin
          starts.push_back(st);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got 0x%0h expected none", b);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'd0, b}, {24'd0, e});
            chk("tx_stop", {31'd0, stp}, 32'd1);
          end
        end
      end
      prev = tx;
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[$];
    logic [9:0] f55;

    tbl.push_back('{1'b0, BASE + 30'd0, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd1, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'hD9});
    tbl.push_back('{1'b0, BASE + 30'd3, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b0, BASE - 30'd1, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b0, 30'h0000_0002, 32'h0,        4'h0, 32'h0});
    tbl.push_back('{1'b1, BASE + 30'd2, 32'h0000_0012, 4'h1, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'h12});
    tbl.push_back('{1'b1, BASE + 30'd2, 32'h0000_3400, 4'h2, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'h3412});
    tbl.push_back('{1'b1, BASE + 30'd2, 32'h0000_5600, 4'h1, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'h3400});
    tbl.push_back('{1'b1, BASE - 30'd2, 32'h0000_1111, 4'h3, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'h3400});
    tbl.push_back('{1'b1, BASE + 30'd2, 32'hFFFF_0000, 4'hC, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'h3400});
    tbl.push_back('{1'b1, BASE + 30'd3, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd3, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, BASE + 30'd1, 32'h0000_003C, 4'h1, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd1, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, BASE + 30'd2, 32'h0000_0004, 4'h3, 32'h0});
    tbl.push_back('{1'b0, BASE + 30'd2, 32'h0,         4'h0, 32'h4});

    repeat (3) @(negedge clock);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].wdata, tbl[i].mask);
      else rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Single byte 0x55: start bit appears one cycle after the write edge
    exp_q.push_back(8'h55);
    f55 = {1'b1, 8'h55, 1'b0};
    bus_wr(BASE, 32'h55, 4'h1);
    chk("tx55_k0", {31'd0, tx}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      chk($sformatf("tx55_k%0d", k), {31'd0, tx}, {31'd0, f55[(k-1)/4]});
    end
    rd_chk("status_after_55", BASE + 30'd1, 32'h0);
    chk("q55_empty", exp_q.size(), 0);

    // Burst of 10: byte 0 moves to the shifter at once, 1..8 fill the FIFO, 9 drops
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus_addr = BASE; bus_data_w = i; bus_mask_w = 4'h1;
      if (i < 9) exp_q.push_back(8'(i));
    end
    @(negedge clock);
    bus_mask_w = 4'h0;
    rd_chk("status_burst", BASE + 30'd1, 32'h0B);
    wait_drain(600, "burst_drain");
    repeat (6) @(negedge clock);
    chk("burst_frames", starts.size(), 9);
    for (int i = 1; i < 9 && i < starts.size(); i++)
      chk($sformatf("burst_gap%0d", i), starts[i] - starts[i-1], 40);
    rd_chk("status_ovf", BASE + 30'd1, 32'h08);
    bus_wr(BASE + 30'd1, 32'h08, 4'h1);
    rd_chk("status_ovf_clr", BASE + 30'd1, 32'h0);

    // Receive path
    send_rx(8'hA3, 1'b1);
    rd_chk("rx_a3", BASE, 32'h1A3);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd_chk("status_rxv", BASE + 30'd1, 32'h04);
    bus_wr(BASE + 30'd1, 32'h04, 4'h1);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("rx_a3_consumed", BASE, 32'h0A3);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk("rx_ovr_data", BASE, 32'h122);
    rd_chk("rx_ovr_status", BASE + 30'd1, 32'h14);
    send_rx(8'h5A, 1'b0);
    rd_chk("ferr_status", BASE + 30'd1, 32'h34);
    rd_chk("ferr_data", BASE, 32'h122);
    bus_wr(BASE + 30'd1, 32'h3C, 4'h1);
    rd_chk("flags_clr", BASE + 30'd1, 32'h0);

    // Reset in the middle of a TX frame and an RX frame
    bus_wr(BASE, 32'hC3, 4'h1);
    bus_wr(BASE, 32'h3C, 4'h1);
    fork
      send_rx(8'h66, 1'b1);
      begin
        repeat (14) @(negedge clock);
        exp_q.delete();
        reset = 1'b0;
        rst_cnt++;
        #1 chk("rst_mid_tx", {31'd0, tx}, 32'd1);
      end
    join
    rd_chk("rst_mid_data", BASE, 32'h0);
    rd_chk("rst_mid_status", BASE + 30'd1, 32'h0);
    rd_chk("rst_mid_div", BASE + 30'd2, 32'hD9);
    @(negedge clock);
    reset = 1'b1;
    repeat (45) @(negedge clock);
    bus_wr(BASE + 30'd2, 32'h4, 4'h3);
    exp_q.push_back(8'hE7);
    bus_wr(BASE, 32'hE7, 4'h1);
    wait_drain(200, "post_rst_drain");
    repeat (6) @(negedge clock);
    rd_chk("post_rst_status", BASE + 30'd1, 32'h0);
    rd_chk("post_rst_data", BASE, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
